// File: rtl/wt_be_split_fsm.sv
// Byte-enable splitter: breaks one masked write into naturally aligned power-of-two
// sub-requests, emitted lowest byte first.
module wt_be_split_fsm #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned ID_WIDTH    = 2,
  parameter bit          SWAP_ENDIAN = 1'b0,
  localparam int unsigned NBYTES     = DATA_WIDTH / 8,
  localparam int unsigned OFF_W      = $clog2(NBYTES),
  localparam int unsigned CNT_W      = $clog2(NBYTES) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  input  logic [NBYTES-1:0]     req_be_i,
  input  logic [ID_WIDTH-1:0]   req_id_i,
  output logic                  sub_valid_o,
  input  logic                  sub_ready_i,
  output logic [ADDR_WIDTH-1:0] sub_addr_o,
  output logic [DATA_WIDTH-1:0] sub_data_o,
  output logic [NBYTES-1:0]     sub_be_o,
  output logic [2:0]            sub_size_o,
  output logic [ID_WIDTH-1:0]   sub_id_o,
  output logic                  sub_last_o,
  output logic [CNT_W-1:0]      sub_cnt_o
);

  localparam int unsigned LANE_BYTES = (NBYTES >= 8) ? 8 : NBYTES;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(NBYTES - 1);

  typedef enum logic {StIdle, StSplit} state_e;

  state_e                state_q, state_d;
  logic [NBYTES-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  logic [OFF_W-1:0]  low_idx;
  logic [NBYTES-1:0] chunk_be;
  logic [NBYTES-1:0] win;
  logic [2:0]        chunk_size;
  logic              last;
  logic              sub_fire;
  logic              req_fire;

  // Grow the window from the lowest pending byte while it stays aligned and fully
  // enabled; once a size fails, every larger size fails too.
  always_comb begin
    low_idx = '0;
    for (int b = NBYTES - 1; b >= 0; b--) begin
      if (rem_q[b]) low_idx = OFF_W'(b);
    end
    chunk_be   = '0;
    chunk_size = '0;
    win        = '0;
    for (int k = 0; k <= OFF_W; k++) begin
      win = ({NBYTES{1'b1}} >> (NBYTES - (1 << k))) << low_idx;
      if (((int'(low_idx) & ((1 << k) - 1)) == 0) && ((rem_q & win) == win)) begin
        chunk_be   = win;
        chunk_size = 3'(k);
      end
    end
  end

  assign last        = (rem_q & ~chunk_be) == '0;
  assign sub_fire    = (state_q == StSplit) && sub_ready_i;
  assign req_ready_o = !rst_i && ((state_q == StIdle) || (sub_fire && last));
  assign req_fire    = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    id_d    = id_q;
    if (sub_fire) begin
      rem_d = rem_q & ~chunk_be;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) state_d = StIdle;
    end
    // A new request overrides the completion above (back-to-back acceptance).
    if (req_fire) begin
      addr_d  = req_addr_i & ~OFF_MASK;
      data_d  = req_data_i;
      id_d    = req_id_i;
      rem_d   = req_be_i;
      cnt_d   = '0;
      state_d = (req_be_i != '0) ? StSplit : StIdle;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rem_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    sub_data_o = data_q;
    if (SWAP_ENDIAN) begin
      for (int l = 0; l < int'(NBYTES / LANE_BYTES); l++) begin
        for (int b = 0; b < int'(LANE_BYTES); b++) begin
          sub_data_o[(l * LANE_BYTES + b) * 8 +: 8] =
              data_q[(l * LANE_BYTES + LANE_BYTES - 1 - b) * 8 +: 8];
        end
      end
    end
  end

  assign sub_valid_o = (state_q == StSplit);
  assign sub_addr_o  = addr_q | ADDR_WIDTH'(low_idx);
  assign sub_be_o    = chunk_be;
  assign sub_size_o  = chunk_size;
  assign sub_id_o    = id_q;
  assign sub_last_o  = (state_q == StSplit) && last;
  assign sub_cnt_o   = cnt_q;

endmodule
